// File: rtl/pong_score_string_builder.sv
// rtl/pong_score_string_builder.sv - score line builder: saturate, serial BCD convert, frame-synchronous commit
//
// Samples both player scores on i_Update, converts each to two BCD digits with a
// serial shift-add-3 engine, builds the ASCII line "P1 dd<spaces>P2 dd", and only
// publishes it on i_FrameStart so the renderer never sees a torn update.
//
// Ports:
//   i_Clk         system/pixel clock
//   i_Rst_L       synchronous reset, active low
//   i_P1_Score    player 1 binary score
//   i_P2_Score    player 2 binary score
//   i_Update      1-cycle pulse: scores changed, rebuild the string
//   i_FrameStart  1-cycle pulse at start of vertical blanking
//   o_DisplayStr  ASCII string, char 0 (leftmost) in the MSB byte
//   o_Busy        high from sample until commit
//   o_StrValid    1-cycle pulse in the cycle o_DisplayStr takes its new value

module pong_score_string_builder #(
    parameter int c_SCORE_WIDTH = 7,
    parameter int c_SCORE_MAX   = 99,
    parameter int c_MAX_STR_LEN = 15
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic [c_SCORE_WIDTH-1:0]   i_P1_Score,
    input  logic [c_SCORE_WIDTH-1:0]   i_P2_Score,
    input  logic                       i_Update,
    input  logic                       i_FrameStart,
    output logic [c_MAX_STR_LEN*8-1:0] o_DisplayStr,
    output logic                       o_Busy,
    output logic                       o_StrValid
);

    localparam int c_STR_W = c_MAX_STR_LEN * 8;
    localparam int c_CNT_W = $clog2(c_SCORE_WIDTH + 1);

    localparam logic [c_CNT_W-1:0]       c_LAST_BIT = c_CNT_W'(c_SCORE_WIDTH - 1);
    localparam logic [c_SCORE_WIDTH-1:0] c_SAT_VAL  = c_SCORE_WIDTH'(c_SCORE_MAX);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CONV_P1    = 3'd1;
    localparam logic [2:0] CONV_P2    = 3'd2;
    localparam logic [2:0] ASSEMBLE   = 3'd3;
    localparam logic [2:0] WAIT_FRAME = 3'd4;

    function automatic logic [c_SCORE_WIDTH-1:0] saturate(input logic [c_SCORE_WIDTH-1:0] score);
        return (score > c_SAT_VAL) ? c_SAT_VAL : score;
    endfunction

    // One shift-add-3 step: correct any nibble >= 5 so the following left shift
    // carries properly into the next decimal digit, then shift in the next binary bit.
    function automatic logic [7:0] bcd_step(input logic [7:0] bcd, input logic in_bit);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        return {adj[6:0], in_bit};
    endfunction

    // "P1 dd" in the leftmost five characters, "P2 dd" in the rightmost five,
    // spaces everywhere in between.
    function automatic logic [c_STR_W-1:0] build_str(input logic [7:0] bcd1, input logic [7:0] bcd2);
        logic [c_STR_W-1:0] s;
        s = {c_MAX_STR_LEN{8'h20}};
        s[c_STR_W-1 -: 40] = {"P1 ", 4'h3, bcd1[7:4], 4'h3, bcd1[3:0]};
        s[39:0]            = {"P2 ", 4'h3, bcd2[7:4], 4'h3, bcd2[3:0]};
        return s;
    endfunction

    localparam logic [c_STR_W-1:0] c_RESET_STR = build_str(8'h00, 8'h00);

    logic [2:0]               state;
    logic [c_CNT_W-1:0]       bit_cnt;
    logic [c_SCORE_WIDTH-1:0] bin_sr;
    logic [7:0]               bcd_sr;
    logic [7:0]               bcd_next;
    logic [c_SCORE_WIDTH-1:0] p2_lat;
    logic [7:0]               p1_bcd;
    logic [7:0]               p2_bcd;
    logic [c_STR_W-1:0]       shadow;
    logic                     pending;
    logic                     commit;

    assign bcd_next = bcd_step(bcd_sr, bin_sr[c_SCORE_WIDTH-1]);
    assign commit   = (state == WAIT_FRAME) && i_FrameStart;
    assign o_Busy   = (state != IDLE);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bin_sr       <= '0;
            bcd_sr       <= '0;
            p2_lat       <= '0;
            p1_bcd       <= '0;
            p2_bcd       <= '0;
            shadow       <= c_RESET_STR;
            pending      <= 1'b0;
            o_DisplayStr <= c_RESET_STR;
            o_StrValid   <= 1'b0;
        end else begin
            o_StrValid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_Update) begin
                        bin_sr  <= saturate(i_P1_Score);
                        p2_lat  <= saturate(i_P2_Score);
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                        state   <= CONV_P1;
                    end
                end

                CONV_P1: begin
                    bcd_sr  <= bcd_next;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == c_LAST_BIT) begin
                        // Hand the shared shift engine over to player 2.
                        p1_bcd  <= bcd_next;
                        bcd_sr  <= '0;
                        bin_sr  <= p2_lat;
                        bit_cnt <= '0;
                        state   <= CONV_P2;
                    end
                end

                CONV_P2: begin
                    bcd_sr  <= bcd_next;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == c_LAST_BIT) begin
                        p2_bcd <= bcd_next;
                        state  <= ASSEMBLE;
                    end
                end

                ASSEMBLE: begin
                    shadow <= build_str(p1_bcd, p2_bcd);
                    state  <= WAIT_FRAME;
                end

                WAIT_FRAME: begin
                    if (i_FrameStart) begin
                        o_DisplayStr <= shadow;
                        o_StrValid   <= 1'b1;
                        // An update that arrived while busy (or on this very edge)
                        // restarts straight away with the scores as they are now.
                        if (pending || i_Update) begin
                            bin_sr  <= saturate(i_P1_Score);
                            p2_lat  <= saturate(i_P2_Score);
                            bcd_sr  <= '0;
                            bit_cnt <= '0;
                            state   <= CONV_P1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            if (commit) begin
                pending <= 1'b0;
            end else if (o_Busy && i_Update) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pong_score_string_builder.sv
// tb/tb_pong_score_string_builder.sv - directed self-checking bench for pong_score_string_builder

module tb_pong_score_string_builder;

    logic         i_Clk = 1'b0;
    logic         i_Rst_L;
    logic [6:0]   i_P1_Score;
    logic [6:0]   i_P2_Score;
    logic         i_Update;
    logic         i_FrameStart;
    logic [119:0] o_DisplayStr;
    logic         o_Busy;
    logic         o_StrValid;

    always #5 i_Clk = ~i_Clk;

    pong_score_string_builder #(
        .c_SCORE_WIDTH(7),
        .c_SCORE_MAX  (99),
        .c_MAX_STR_LEN(15)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_P1_Score  (i_P1_Score),
        .i_P2_Score  (i_P2_Score),
        .i_Update    (i_Update),
        .i_FrameStart(i_FrameStart),
        .o_DisplayStr(o_DisplayStr),
        .o_Busy      (o_Busy),
        .o_StrValid  (o_StrValid)
    );

    typedef struct {
        logic [6:0]   p1;
        logic [6:0]   p2;
        logic [119:0] exp;
        int           frame_at;
    } vec_t;

    localparam logic [119:0] RST_STR = "P1 00     P2 00";

    vec_t         vecs[7];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           valid_cnt = 0;
    int           start_cnt;
    logic [119:0] last_str;

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge i_Clk);
        @(negedge i_Clk);
        if (o_StrValid) valid_cnt++;
    endtask

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        i_P1_Score = v.p1;
        i_P2_Score = v.p2;
        i_Update   = 1'b1;
        tick();
        i_Update   = 1'b0;
        chk("busy_after_update", o_Busy, 1);
        // Inputs moving during conversion must not leak into the result.
        i_P1_Score = 7'd55;
        i_P2_Score = 7'd66;
        start_cnt  = valid_cnt;
        for (int c = 1; c < v.frame_at; c++) tick();
        chk("no_commit_before_frame", valid_cnt - start_cnt, 0);
        chk("display_held", o_DisplayStr, last_str);
        i_FrameStart = 1'b1;
        tick();
        i_FrameStart = 1'b0;
        chk("commit_valid", o_StrValid, 1);
        chk("commit_string", o_DisplayStr, v.exp);
        last_str = v.exp;
        tick();
        chk("valid_one_cycle", o_StrValid, 0);
        chk("idle_after_commit", o_Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7'd7,   7'd12,  "P1 07     P2 12", 20};
        vecs[1] = '{7'd120, 7'd99,  "P1 99     P2 99", 16};
        vecs[2] = '{7'd0,   7'd10,  "P1 00     P2 10", 16};
        vecs[3] = '{7'd100, 7'd0,   "P1 99     P2 00", 16};
        vecs[4] = '{7'd45,  7'd127, "P1 45     P2 99", 17};
        vecs[5] = '{7'd9,   7'd90,  "P1 09     P2 90", 16};
        vecs[6] = '{7'd98,  7'd59,  "P1 98     P2 59", 25};

        i_Rst_L      = 1'b0;
        i_P1_Score   = 7'd0;
        i_P2_Score   = 7'd0;
        i_Update     = 1'b0;
        i_FrameStart = 1'b0;
        tick();
        tick();
        chk("reset_string", o_DisplayStr, RST_STR);
        chk("reset_busy", o_Busy, 0);
        chk("reset_valid", o_StrValid, 0);
        i_Rst_L  = 1'b1;
        last_str = RST_STR;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Frame pulses while converting (cycle 10) and in ASSEMBLE (cycle 15) are ignored.
        i_P1_Score = 7'd21;
        i_P2_Score = 7'd3;
        i_Update   = 1'b1;
        tick();
        i_Update   = 1'b0;
        start_cnt  = valid_cnt;
        for (int c = 1; c <= 18; c++) begin
            i_FrameStart = (c == 10) || (c == 15) || (c == 18);
            tick();
            i_FrameStart = 1'b0;
            if (c == 17) begin
                chk("early_frames_ignored", valid_cnt - start_cnt, 0);
                chk("early_frames_display", o_DisplayStr, last_str);
            end
        end
        chk("late_frame_valid", o_StrValid, 1);
        chk("late_frame_string", o_DisplayStr, "P1 21     P2 03");
        last_str = "P1 21     P2 03";
        tick();

        // Update and frame together in IDLE: conversion starts, frame ignored.
        i_P1_Score   = 7'd1;
        i_P2_Score   = 7'd2;
        i_Update     = 1'b1;
        i_FrameStart = 1'b1;
        tick();
        i_Update     = 1'b0;
        i_FrameStart = 1'b0;
        chk("idle_both_valid", o_StrValid, 0);
        chk("idle_both_busy", o_Busy, 1);
        chk("idle_both_display", o_DisplayStr, last_str);
        for (int c = 1; c <= 16; c++) begin
            i_FrameStart = (c == 16);
            tick();
            i_FrameStart = 1'b0;
        end
        chk("idle_both_commit", o_DisplayStr, "P1 01     P2 02");
        last_str = "P1 01     P2 02";
        tick();

        // Pending restart: updates at cycles 5 and 9 collapse into one rebuild.
        i_P1_Score = 7'd3;
        i_P2_Score = 7'd5;
        i_Update   = 1'b1;
        tick();
        i_Update   = 1'b0;
        start_cnt  = valid_cnt;
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) i_P1_Score = 7'd4;
            i_Update     = (c == 5) || (c == 9);
            i_FrameStart = (c == 16) || (c == 31) || (c == 32);
            tick();
            i_Update     = 1'b0;
            i_FrameStart = 1'b0;
            if (c == 16) begin
                chk("pending_first_string", o_DisplayStr, "P1 03     P2 05");
                chk("pending_busy_held", o_Busy, 1);
            end
            if (c == 31) chk("pending_assemble_ignored", valid_cnt - start_cnt, 1);
            if (c == 32) chk("pending_second_string", o_DisplayStr, "P1 04     P2 05");
        end
        chk("pending_two_pulses", valid_cnt - start_cnt, 2);
        chk("pending_idle_after", o_Busy, 0);
        last_str = "P1 04     P2 05";

        // Reset during CONV_P2 (cycle 10).
        i_P1_Score = 7'd50;
        i_P2_Score = 7'd60;
        i_Update   = 1'b1;
        tick();
        i_Update   = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        i_Rst_L = 1'b0;
        tick();
        chk("midreset_string", o_DisplayStr, RST_STR);
        chk("midreset_busy", o_Busy, 0);
        chk("midreset_valid", o_StrValid, 0);
        i_Rst_L   = 1'b1;
        start_cnt = valid_cnt;
        for (int c = 1; c <= 20; c++) begin
            i_FrameStart = (c == 5) || (c == 16) || (c == 18);
            tick();
            i_FrameStart = 1'b0;
        end
        chk("midreset_no_commit", valid_cnt - start_cnt, 0);
        chk("midreset_string_kept", o_DisplayStr, RST_STR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
